// File: rtl/prog_load_pkg.sv
// Shared types and constants for the UART program loader: FSM encodings,
// frame length width and 8N1 framing constants.
package prog_load_pkg;

  localparam int unsigned LEN_W          = 16;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;
  localparam logic        UART_START_LVL = 1'b0;
  localparam logic        UART_STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } load_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_t;

  // Clocks per UART bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/prog_load_ctrl_uart_rx.sv
// 8N1 UART byte receiver, mid-bit sampling. Expects an already synchronized
// serial input; emits one-cycle rx_valid / rx_ferr pulses.
module uart_rx
  import prog_load_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

  rx_state_t                   st, st_n;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic [BIT_W-1:0]            bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0]   sh, sh_n;
  logic                        valid_q, valid_n;
  logic                        ferr_q, ferr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (st)
      RX_IDLE: begin
        if (rx == UART_START_LVL) begin
          st_n  = RX_START;
          cnt_n = '0;
        end
      end
      // Start bit must still be low at mid-bit, else treat it as a glitch.
      RX_START: begin
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_n = '0;
          if (rx == UART_START_LVL) begin
            st_n  = RX_DATA;
            bit_n = '0;
          end else begin
            st_n = RX_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CNT_W'(DIV - 1)) begin
          cnt_n = '0;
          sh_n  = {rx, sh[UART_DATA_BITS-1:1]};
          if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
            st_n = RX_STOP;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CNT_W'(DIV - 1)) begin
          cnt_n = '0;
          if (rx == UART_STOP_LVL) begin
            valid_n = 1'b1;
            st_n    = RX_IDLE;
          end else begin
            ferr_n = 1'b1;
            st_n   = RX_WAIT_HI;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      // After a bad stop bit the line may still be low; wait for idle.
      RX_WAIT_HI: begin
        if (rx == UART_STOP_LVL) st_n = RX_IDLE;
      end
      default: st_n = RX_IDLE;
    endcase
  end

  assign rx_byte  = sh;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/prog_load_ctrl.sv
// UART program loader: receives a length-prefixed word stream and writes it
// into instruction memory while holding the CPU in stall.
module prog_load_ctrl
  import prog_load_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pg,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned     GAP_W     = $clog2(TIMEOUT_CYC + 1);
  localparam longint unsigned MAX_WORDS = 64'd1 << ADDR_W;

  logic start_meta, start_sync, start_prev;
  logic rx_meta, rx_sync;
  logic start_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
    end else begin
      start_meta <= start_pg;
      start_sync <= start_meta;
      start_prev <= start_sync;
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
    end
  end

  assign start_rise = start_sync & ~start_prev;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx_sync),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  load_state_t        state, state_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [7:0]         len_lo_q, len_lo_n;
  logic [ADDR_W:0]    idx, idx_n;
  logic [1:0]         bcnt, bcnt_n;
  logic [31:0]        word, word_n;
  logic [GAP_W-1:0]   gap, gap_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [31:0]        wdata_q, wdata_n;

  logic               load_active;
  logic               timed_out;
  logic [LEN_W-1:0]   len_rx;
  logic [ADDR_W:0]    idx_inc;
  logic [31:0]        word_shift;

  assign load_active = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                       (state == ST_DATA)   || (state == ST_WRITE);
  assign timed_out   = (gap == GAP_W'(TIMEOUT_CYC));
  assign len_rx      = {rx_byte, len_lo_q};
  assign idx_inc     = idx + (ADDR_W + 1)'(1);
  assign word_shift  = {rx_byte, word[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      len_lo_q <= '0;
      idx      <= '0;
      bcnt     <= '0;
      word     <= '0;
      gap      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      len_lo_q <= len_lo_n;
      idx      <= idx_n;
      bcnt     <= bcnt_n;
      word     <= word_n;
      gap      <= gap_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
    end
  end

  always_comb begin
    state_n  = state;
    len_n    = len_q;
    len_lo_n = len_lo_q;
    idx_n    = idx;
    bcnt_n   = bcnt;
    word_n   = word;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    gap_n    = gap;
    if (load_active && !timed_out) gap_n = gap + GAP_W'(1);
    if (rx_valid) gap_n = '0;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_rise) begin
          state_n = ST_LEN_LO;
          gap_n   = '0;
        end
      end
      ST_LEN_LO: begin
        if (rx_ferr || timed_out) begin
          state_n = ST_ERR;
        end else if (rx_valid) begin
          len_lo_n = rx_byte;
          state_n  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_ferr || timed_out) begin
          state_n = ST_ERR;
        end else if (rx_valid) begin
          len_n  = len_rx;
          idx_n  = '0;
          bcnt_n = '0;
          if (len_rx == '0)                     state_n = ST_DONE;
          else if (64'(len_rx) > MAX_WORDS)     state_n = ST_ERR;
          else                                  state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_ferr || timed_out) begin
          state_n = ST_ERR;
        end else if (rx_valid) begin
          word_n = word_shift;
          bcnt_n = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            state_n = ST_WRITE;
            addr_n  = idx[ADDR_W-1:0];
            wdata_n = word_shift;
          end
        end
      end
      ST_WRITE: begin
        idx_n = idx_inc;
        if (32'(idx_inc) == 32'(len_q)) state_n = ST_DONE;
        else                            state_n = ST_DATA;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Status outputs decode directly from state so stall drops on DONE/ERR entry.
  assign mem_we    = (state == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_stall = load_active;
  assign load_done = (state == ST_DONE);
  assign load_err  = (state == ST_ERR);

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: table of whole frames plus hand-written
// sequences for idle, framing error, timeout, ignored restart and mid-load reset.
module tb_prog_load_ctrl;

  localparam int unsigned CLK_FREQ    = 1000000;
  localparam int unsigned BAUD        = 100000;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned TIMEOUT_CYC = 2000;
  localparam int          BIT_CYC     = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_pg;
  logic              rx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_stall;
  logic              load_done;
  logic              load_err;

  prog_load_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_pg  (start_pg),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_stall (cpu_stall),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          wr_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_log [64];
  logic [31:0]       wr_data_log [64];

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] = mem_addr;
        wr_data_log[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
  end

  typedef struct {
    int           nb;
    logic [111:0] bytes;   // first byte in [7:0]
    int           nw;
    logic [95:0]  words;   // word 0 in [31:0]
    logic         done;
    logic         err;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_pg = 1'b1;
    repeat (4) @(negedge clk);
    start_pg = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int           base;
  int           nz;
  logic [7:0]   b;
  logic [31:0]  w;
  logic [111:0] bv;
  logic [95:0]  wv;

  initial begin
    rst = 1'b1; start_pg = 1'b0; rx = 1'b1;
    vt[0] = '{10, 112'h0050_00B3_0000_0013_0002, 2, 96'h0000_0000_0050_00B3_0000_0013, 1'b1, 1'b0};
    vt[1] = '{2,  112'h0000,                     0, 96'h0,                             1'b1, 1'b0};
    vt[2] = '{2,  112'h0011,                     0, 96'h0,                             1'b0, 1'b1};
    vt[3] = '{6,  112'hDEAD_BEEF_0001,           1, 96'hDEADBEEF,                      1'b1, 1'b0};
    vt[4] = '{14, 112'h0C0B_0A09_0807_0605_0403_0201_0003, 3,
              96'h0C0B0A09_08070605_04030201, 1'b1, 1'b0};
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state and quiet idle
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_err", load_err, 0);
    nz = 0;
    repeat (10000) begin
      @(negedge clk);
      if (mem_we || cpu_stall || load_done || load_err || (|mem_addr) || (|mem_wdata)) nz++;
    end
    chk("idle_quiet_cycles", nz, 0);

    // Framing error during DATA
    base = wr_cnt;
    pulse_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    chk("ferr_load_err", load_err, 1);
    chk("ferr_cpu_stall", cpu_stall, 0);
    chk("ferr_load_done", load_done, 0);
    chk("ferr_writes", wr_cnt - base, 0);

    // Table of complete frames, first one recovers from the error above
    for (int i = 0; i < 5; i++) begin
      base = wr_cnt;
      bv = vt[i].bytes;
      wv = vt[i].words;
      pulse_start();
      chk($sformatf("v%0d_stall_at_start", i), cpu_stall, 1);
      chk($sformatf("v%0d_done_cleared", i), load_done, 0);
      chk($sformatf("v%0d_err_cleared", i), load_err, 0);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      for (int k = 0; k < vt[i].nb - 1; k++) begin
        b = bv[8*k +: 8];
        send_byte(b, 1'b1);
      end
      chk($sformatf("v%0d_stall_mid_frame", i), cpu_stall, 1);
      b = bv[8*(vt[i].nb-1) +: 8];
      send_byte(b, 1'b1);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_write_count", i), wr_cnt - base, vt[i].nw);
      for (int j = 0; j < vt[i].nw; j++) begin
        w = wv[32*j +: 32];
        chk($sformatf("v%0d_w%0d_addr", i, j), wr_addr_log[base+j], j);
        chk($sformatf("v%0d_w%0d_data", i, j), wr_data_log[base+j], w);
      end
      chk($sformatf("v%0d_load_done", i), load_done, vt[i].done);
      chk($sformatf("v%0d_load_err", i), load_err, vt[i].err);
      chk($sformatf("v%0d_cpu_stall_end", i), cpu_stall, 0);
      chk($sformatf("v%0d_mem_we_end", i), mem_we, 0);
      if (vt[i].nw > 0) begin
        w = wv[32*(vt[i].nw-1) +: 32];
        chk($sformatf("v%0d_addr_hold", i), mem_addr, vt[i].nw - 1);
        chk($sformatf("v%0d_wdata_hold", i), mem_wdata, w);
      end
    end

    // Inter-byte timeout with a partial word
    base = wr_cnt;
    pulse_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    repeat (TIMEOUT_CYC - 300) @(negedge clk);
    chk("to_err_before", load_err, 0);
    chk("to_stall_before", cpu_stall, 1);
    repeat (600) @(negedge clk);
    chk("to_load_err", load_err, 1);
    chk("to_cpu_stall", cpu_stall, 0);
    chk("to_load_done", load_done, 0);
    chk("to_writes", wr_cnt - base, 0);

    // Ignored restart during DATA, then reset after the first of three words
    base = wr_cnt;
    pulse_start();
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("rr_first_write_count", wr_cnt - base, 1);
    chk("rr_first_write_data", wr_data_log[base], 32'h44332211);
    pulse_start();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    chk("rr_restart_ignored_stall", cpu_stall, 1);
    chk("rr_restart_ignored_err", load_err, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rr_rst_load_err", load_err, 0);
    chk("rr_rst_load_done", load_done, 0);
    chk("rr_rst_cpu_stall", cpu_stall, 0);
    chk("rr_rst_mem_addr", mem_addr, 0);
    chk("rr_rst_mem_wdata", mem_wdata, 0);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    send_byte(8'h99, 1'b1);
    send_byte(8'hAA, 1'b1);
    repeat (10) @(negedge clk);
    chk("rr_only_one_write", wr_cnt - base, 1);
    chk("rr_idle_stall", cpu_stall, 0);
    chk("rr_idle_done", load_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning UART bit rate.
REQ-003 The block SHALL have parameter ADDR_W, default 14, meaning instruction-memory word-address width.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1000000, meaning the maximum inter-byte gap in clocks during a load.
REQ-005 The block SHALL have port clk, input, 1, meaning the single system clock.
REQ-006 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 The block SHALL have port start_pg, input, 1, meaning an asynchronous level request to enter program-load mode.
REQ-008 The block SHALL have port rx, input, 1, meaning the asynchronous UART serial input, idle high.
REQ-009 The block SHALL have port mem_we, output, 1, meaning the instruction-memory write strobe.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W, meaning the instruction-memory word address.
REQ-011 The block SHALL have port mem_wdata, output, 32, meaning the instruction-memory write data.
REQ-012 The block SHALL have port cpu_stall, output, 1, meaning that the CPU is held and the memory port is owned by the loader.
REQ-013 The block SHALL have port load_done, output, 1, meaning the last load completed successfully.
REQ-014 The block SHALL have port load_err, output, 1, meaning the last load aborted.

Function
REQ-015 The block SHALL pass start_pg and rx through 2-flop synchronizers and act only on the synchronized rising edge of start_pg.
REQ-016 The block SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERR.
REQ-017 On a start_pg rise in IDLE, DONE or ERR, the block SHALL go to LEN_LO, clear load_done and load_err, and assert cpu_stall on the next cycle.
REQ-018 The block SHALL ignore start_pg rises while in LEN_LO, LEN_HI, DATA or WRITE.
REQ-019 The frame SHALL be: word count N as 2 bytes little-endian, then 4N data bytes, with each word little-endian (first byte = bits 7:0).
REQ-020 N = 0 SHALL go directly from LEN_HI to DONE with no memory writes.
REQ-021 N greater than 2^ADDR_W SHALL go from LEN_HI to ERR.
REQ-022 After each 4th data byte, the block SHALL spend exactly one WRITE cycle with mem_we = 1, mem_addr = word index (starting at 0), and mem_wdata = the assembled word.
REQ-023 After a WRITE, the block SHALL increment the word index and go to DONE if the index equals N, otherwise to DATA.
REQ-024 mem_we SHALL be 0 in every state other than WRITE.
REQ-025 mem_addr and mem_wdata SHALL hold their last values when mem_we is 0.
REQ-026 cpu_stall SHALL be 1 in LEN_LO, LEN_HI, DATA and WRITE, and 0 otherwise.
REQ-027 The block SHALL clear cpu_stall on the cycle that DONE or ERR is entered.
REQ-028 load_done SHALL be 1 in DONE and load_err SHALL be 1 in ERR; both SHALL be sticky until the next accepted start_pg rise or reset.
REQ-029 An idle-gap counter SHALL reset on every received byte and on entering LEN_LO.
REQ-030 If the idle-gap counter reaches TIMEOUT_CYC in LEN_LO, LEN_HI or DATA, the block SHALL enter ERR; a partial word SHALL be discarded.
REQ-031 A UART framing error (stop bit = 0) in any load state SHALL cause entry to ERR.
REQ-032 Bytes received in IDLE, DONE or ERR SHALL be discarded.
REQ-033 The UART receiver SHALL sample at mid-bit using a divider of CLK_FREQ/BAUD rounded to nearest, format 8N1, LSB first.
REQ-034 The UART receiver SHALL re-check the start bit at mid-bit and reject glitches shorter than half a bit.

Reset
REQ-035 On rst = 1 at a clk edge, the block SHALL enter IDLE and set mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_stall = 0, load_done = 0, load_err = 0, and clear all counters and the receiver.
REQ-036 Reset mid-load SHALL abandon the frame with no further writes and SHALL NOT assert load_err.

Structure
REQ-037 The state encoding, the frame length width (16) and the UART 8N1 constants SHALL live in the shared package prog_load_pkg.
REQ-038 The UART byte receiver SHALL be a separate sub-module uart_rx with outputs rx_byte[7:0], rx_valid (1-cycle pulse) and rx_ferr.

Verification
REQ-039 After reset, with no stimulus, the bench SHALL check that all outputs are 0 and remain 0 for 10000 cycles.
REQ-040 Start_pg rise, then bytes 02 00 13 00 00 00 B3 00 50 00 -> the bench SHALL see exactly two writes, [0] = 0x00000013 and [1] = 0x005000B3, then load_done = 1 and cpu_stall = 0.
REQ-041 Start_pg rise, then bytes 00 00 -> the bench SHALL see no write, load_done = 1, and cpu_stall high for only the frame duration.
REQ-042 Start_pg rise, then 01 00 AA BB and then silence -> after TIMEOUT_CYC the bench SHALL see load_err = 1, no write, and cpu_stall = 0.
REQ-043 A second start_pg rise during DATA, and rst asserted after the first of three words -> the bench SHALL see the rise ignored, only [0] written, and IDLE with load_err = 0 after reset.
REQ-044 A byte with stop bit = 0 during DATA -> the bench SHALL see ERR; a following valid start_pg rise and frame SHALL load correctly.
